// File: rtl/tc_pkg.sv
// Shared sizing and FSM state type for the merge-tree controller and its tree.
package tc_pkg;
    localparam int DW_DATA = 16;
    localparam int N_UNIT  = 64;
    localparam int N_MERGE = 16;
    localparam int TILE_K  = 4;
    localparam int DW_K    = 8;
    localparam int MT_LAT  = 2;

    // Every merge output consumes exactly TILE_K multiplier lanes
    localparam bit TILE_CFG_OK = (N_UNIT == N_MERGE * TILE_K);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_OUT
    } tc_state_t;
endpackage

// File: rtl/tc_mergetree.sv
// Adder tree: each merge lane sums TILE_K products plus its partial sum, mod 2^DW_DATA,
// delivered MT_LAT cycles after the inputs are presented.
module tc_mergetree #(
    parameter int N_UNIT  = 64,
    parameter int N_MERGE = 16,
    parameter int DW_DATA = 16,
    parameter int MT_LAT  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_UNIT*DW_DATA-1:0]  in_mult,
    input  logic [N_MERGE*DW_DATA-1:0] in_psum,
    output logic [N_MERGE*DW_DATA-1:0] out
);
    localparam int TK = N_UNIT / N_MERGE;
    localparam int PW = N_MERGE * DW_DATA;

    logic [PW-1:0] sum;
    logic [PW-1:0] pipe [MT_LAT];

    always_comb begin
        sum = in_psum;
        for (int m = 0; m < N_MERGE; m++) begin
            for (int j = 0; j < TK; j++) begin
                sum[m*DW_DATA +: DW_DATA] = sum[m*DW_DATA +: DW_DATA]
                                          + in_mult[(m*TK + j)*DW_DATA +: DW_DATA];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MT_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= sum;
            for (int i = 1; i < MT_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out = pipe[MT_LAT-1];
endmodule

// File: rtl/tc_mergetree_ctrl.sv
// Sequences one output tile through an external tc_mergetree: k feed/wait rounds,
// then presents the accumulated partial sums until the consumer takes them.
//
//   state | meaning
//   IDLE  | waiting for start
//   FEED  | ready for the next product vector
//   WAIT  | vector issued, waiting MT_LAT cycles for the tree result
//   OUT   | result tile presented, waiting for out_ready
module tc_mergetree_ctrl
    import tc_pkg::tc_state_t, tc_pkg::ST_IDLE, tc_pkg::ST_FEED,
           tc_pkg::ST_WAIT, tc_pkg::ST_OUT, tc_pkg::TILE_K, tc_pkg::TILE_CFG_OK;
#(
    parameter int N_UNIT  = tc_pkg::N_UNIT,
    parameter int N_MERGE = tc_pkg::N_MERGE,
    parameter int DW_DATA = tc_pkg::DW_DATA,
    parameter int DW_K    = tc_pkg::DW_K,
    parameter int MT_LAT  = tc_pkg::MT_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DW_K-1:0]            cfg_k_steps,
    input  logic [N_MERGE*DW_DATA-1:0] init_psum,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_UNIT*DW_DATA-1:0]  in_mult,
    output logic [N_UNIT*DW_DATA-1:0]  mt_mult,
    output logic [N_MERGE*DW_DATA-1:0] mt_psum,
    input  logic [N_MERGE*DW_DATA-1:0] mt_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_MERGE*DW_DATA-1:0] out_data,
    output logic                       done
);
    localparam int PW = N_MERGE * DW_DATA;
    localparam int MW = N_UNIT * DW_DATA;
    localparam int WW = $clog2(MT_LAT + 1);

    if (!TILE_CFG_OK || N_UNIT != N_MERGE * TILE_K) begin : g_cfg_err
        $error("tc_mergetree_ctrl: N_UNIT must equal N_MERGE*TILE_K");
    end

    tc_state_t       state, state_nxt;
    logic [DW_K-1:0] k, step_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [PW-1:0]   psum_reg;
    logic [MW-1:0]   mult_q;
    logic [PW-1:0]   psum_q;
    logic            done_q;
    logic            accept_start, feed_fire, capture, out_fire, last_step;

    // Compared one bit wider so k = 2^DW_K-1 terminates without step_cnt wrapping
    assign last_step = ({1'b0, step_cnt} + {{DW_K{1'b0}}, 1'b1}) == {1'b0, k};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        feed_fire    = 1'b0;
        capture      = 1'b0;
        out_fire     = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                accept_start = 1'b1;
                state_nxt    = (cfg_k_steps == '0) ? ST_OUT : ST_FEED;
            end
            ST_FEED: if (in_valid) begin
                feed_fire = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: if (wait_cnt == '0) begin
                capture   = 1'b1;
                state_nxt = last_step ? ST_OUT : ST_FEED;
            end
            ST_OUT: if (out_ready) begin
                out_fire  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k        <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
            psum_reg <= '0;
            mult_q   <= '0;
            psum_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            if (accept_start) begin
                k        <= cfg_k_steps;
                step_cnt <= '0;
                psum_reg <= init_psum;
            end else if (capture) begin
                step_cnt <= step_cnt + DW_K'(1);
                psum_reg <= mt_out;
            end

            if (feed_fire)              wait_cnt <= WW'(MT_LAT);
            else if (state == ST_WAIT)  wait_cnt <= wait_cnt - WW'(1);

            // Tree inputs are live only in the issue cycle so idle cycles feed zeros
            mult_q <= feed_fire ? in_mult  : '0;
            psum_q <= feed_fire ? psum_reg : '0;
            done_q <= out_fire;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign in_ready  = (state == ST_FEED);
    assign out_valid = (state == ST_OUT);
    assign out_data  = out_valid ? psum_reg : '0;
    assign mt_mult   = mult_q;
    assign mt_psum   = psum_q;
    assign done      = done_q;
endmodule

// File: tb/tb_tc_mergetree_ctrl.sv
// Bench: controller paired with tc_mergetree, directed tiles plus randomized tiles
// checked against a whole-tile sum model.
module tb_tc_mergetree_ctrl;
    import tc_pkg::*;

    localparam int MW = N_UNIT * DW_DATA;
    localparam int PW = N_MERGE * DW_DATA;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [DW_K-1:0] cfg_k_steps = '0;
    logic [PW-1:0]   init_psum = '0;
    logic            in_valid = 1'b0;
    logic [MW-1:0]   in_mult = '0;
    logic            out_ready = 1'b0;
    logic            busy, in_ready, out_valid, done;
    logic [MW-1:0]   mt_mult;
    logic [PW-1:0]   mt_psum, mt_out, out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mt_viol  = 0;
    int done_viol = 0;
    int hs_cnt   = 0;
    bit hs_prev  = 1'b0;
    bit done_prev = 1'b0;
    logic [PW-1:0] last_out;

    always #5 clk = ~clk;

    tc_mergetree_ctrl #(
        .N_UNIT(N_UNIT), .N_MERGE(N_MERGE), .DW_DATA(DW_DATA), .DW_K(DW_K), .MT_LAT(MT_LAT)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .cfg_k_steps(cfg_k_steps),
        .init_psum(init_psum), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_mult(in_mult), .mt_mult(mt_mult), .mt_psum(mt_psum), .mt_out(mt_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
    );

    tc_mergetree #(
        .N_UNIT(N_UNIT), .N_MERGE(N_MERGE), .DW_DATA(DW_DATA), .MT_LAT(MT_LAT)
    ) u_mt (
        .clk(clk), .reset(reset), .in_mult(mt_mult), .in_psum(mt_psum), .out(mt_out)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tree inputs may be non-zero only the cycle after a handshake; done is one cycle wide
    always @(negedge clk) begin
        if ((mt_mult != '0 || mt_psum != '0) && !hs_prev) mt_viol <= mt_viol + 1;
        if (done && done_prev) done_viol <= done_viol + 1;
        if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
        hs_prev   <= in_valid && in_ready;
        done_prev <= done;
    end

    function automatic logic [MW-1:0] gen_vec(input int kind);
        logic [MW-1:0] v;
        for (int i = 0; i < N_UNIT; i++) begin
            case (kind)
                1:       v[i*DW_DATA +: DW_DATA] = DW_DATA'(1);
                2:       v[i*DW_DATA +: DW_DATA] = '1;
                default: v[i*DW_DATA +: DW_DATA] = DW_DATA'($urandom);
            endcase
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] fill(input int val);
        logic [PW-1:0] v;
        for (int m = 0; m < N_MERGE; m++) v[m*DW_DATA +: DW_DATA] = DW_DATA'(val);
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_psum();
        logic [PW-1:0] v;
        for (int m = 0; m < N_MERGE; m++) v[m*DW_DATA +: DW_DATA] = DW_DATA'($urandom);
        return v;
    endfunction

    // New lane value = old lane + its TILE_K products, kept modulo 2^DW_DATA
    function automatic logic [PW-1:0] model_step(input logic [PW-1:0] psum, input logic [MW-1:0] v);
        logic [PW-1:0] r;
        int acc;
        for (int m = 0; m < N_MERGE; m++) begin
            acc = int'(psum[m*DW_DATA +: DW_DATA]);
            for (int j = 0; j < TILE_K; j++) acc += int'(v[(m*TILE_K + j)*DW_DATA +: DW_DATA]);
            r[m*DW_DATA +: DW_DATA] = DW_DATA'(acc);
        end
        return r;
    endfunction

    // Entered at a falling edge with the DUT idle (or in its done cycle)
    task automatic run_tile(input int k, input logic [PW-1:0] init, input int kind,
                            input bit b2b, input int stall, input bit poke);
        logic [PW-1:0] exp_psum;
        logic [MW-1:0] vec;
        int lat, hs0, bad, gap;
        exp_psum = init;
        hs0 = hs_cnt;
        start = 1'b1; cfg_k_steps = DW_K'(k); init_psum = init; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; cfg_k_steps = DW_K'($urandom); init_psum = rand_psum();
        if (k == 0) begin
            @(negedge clk);
            check("k0_out_next", out_valid, 1);
        end else begin
            for (int s = 0; s < k; s++) begin
                vec = gen_vec(kind);
                if (poke) begin
                    start = 1'b1; cfg_k_steps = DW_K'($urandom); out_ready = 1'($urandom);
                end
                if (s == 0 || b2b) begin
                    in_valid = 1'b1; in_mult = vec;
                end else begin
                    in_valid = 1'b0;
                end
                if (s > 0) begin
                    lat = 0;
                    do begin @(negedge clk); lat++; end while (!in_ready && lat < 20);
                    check("step_lat", lat, MT_LAT + 1);
                    if (!b2b) begin
                        gap = $urandom_range(0, 2);
                        @(posedge clk); #1;
                        repeat (gap) begin @(posedge clk); #1; end
                        in_valid = 1'b1; in_mult = vec;
                    end
                end
                lat = 0;
                while (!(in_valid && in_ready) && lat < 20) begin @(negedge clk); lat++; end
                check("feed_hs", in_valid && in_ready, 1);
                @(posedge clk); #1;
                in_valid = 1'b0; in_mult = gen_vec(0); start = 1'b0; out_ready = 1'b0;
                @(negedge clk);
                for (int q = 0; q < MW / 256; q++) check("mt_mult", mt_mult[q*256 +: 256], vec[q*256 +: 256]);
                check("mt_psum", mt_psum, exp_psum);
                exp_psum = model_step(exp_psum, vec);
                @(posedge clk); #1;
            end
            lat = 0;
            do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
            check("out_lat", lat, MT_LAT + 1);
        end
        check("out_data", out_data, exp_psum);
        check("busy_out", busy, 1);
        last_out = out_data;
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (poke) begin
                start = 1'b1; cfg_k_steps = DW_K'($urandom); in_valid = 1'b1; in_mult = gen_vec(0);
            end
            @(negedge clk);
            if (!out_valid || out_data !== exp_psum || done) bad++;
        end
        if (stall > 0) check("out_hold", bad, 0);
        @(posedge clk); #1;
        out_ready = 1'b1; start = 1'b0; in_valid = 1'b0; in_mult = '0;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'($urandom);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("idle_after", busy, 0);
        check("hs_count", hs_cnt - hs0, k);
    endtask

    initial begin
        int k;
        #2;
        check("rst_outputs", {busy, in_ready, out_valid, done, |out_data, |mt_mult, |mt_psum}, 0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold", {busy, in_ready, out_valid, done, |out_data, |mt_mult, |mt_psum}, 0);
        start = 1'b0;
        reset = 1'b1;

        run_tile(1, fill(1), 1, 1'b1, 0, 1'b0);
        check("res_k1_ones", last_out, fill(5));
        run_tile(3, fill(1), 1, 1'b1, 0, 1'b0);
        check("res_k3_ones", last_out, fill(13));
        run_tile(1, fill(0), 2, 1'b0, 0, 1'b0);
        check("res_wrap", last_out, fill(16'hFFFC));
        run_tile(0, fill(7), 0, 1'b0, 0, 1'b0);
        check("res_k0", last_out, fill(7));
        run_tile(2, rand_psum(), 0, 1'b0, 5, 1'b1);

        // Reset landing in WAIT of a k=4 tile while the tree inputs are live
        start = 1'b1; cfg_k_steps = DW_K'(4); init_psum = rand_psum();
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_mult = gen_vec(0);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_mid_tile", {busy, in_ready, out_valid, done, |out_data, |mt_mult, |mt_psum}, 0);
        repeat (3) @(negedge clk);
        check("rst_no_done", {busy, done}, 0);
        reset = 1'b1;
        run_tile(1, fill(1), 1, 1'b1, 0, 1'b0);
        check("res_after_rst", last_out, fill(5));

        for (int t = 0; t < 14; t++) begin
            k = $urandom_range(0, 6);
            run_tile(k, rand_psum(), $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
        run_tile(255, rand_psum(), 0, 1'b1, 1, 1'b0);

        check("mt_idle_zero", mt_viol, 0);
        check("done_width", done_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
